// File: rtl/ring_ctr_pkg.sv
// ring_ctr_pkg: mode type, seed value and index-width helper shared by the ring/Johnson counter
package ring_ctr_pkg;
  typedef enum logic {MODE_JOHNSON = 1'b0, MODE_RING = 1'b1} mode_t;
  function automatic logic [31:0] seed_of(input mode_t m);
    return {31'd0, m == MODE_RING};
  endfunction
  function automatic int idx_w(input int w);
    return $clog2(2 * w);
  endfunction
endpackage

// File: rtl/shift_ctr_decode.sv
// shift_ctr_decode: legality and sequence position of a ring or Johnson counter state
module shift_ctr_decode
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDXW  = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  output logic             legal,
  output logic [IDXW-1:0]  idx
);
  int pc, tr, pos, raw;
  always_comb begin
    pc  = 0;
    tr  = 0;
    pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pc  += int'(q[i]);
      pos  = q[i] ? i : pos;
    end
    // a Johnson state is one contiguous run of ones touching an end: at most one adjacent change
    for (int i = 0; i < WIDTH - 1; i++) tr += int'(q[i] ^ q[i+1]);
    legal = (mode == MODE_RING) ? (pc == 1) : (tr <= 1);
    raw   = (mode == MODE_RING) ? (WIDTH - pos) % WIDTH : (q[0] ? 2 * WIDTH - pc : pc);
    idx   = legal ? IDXW'(raw) : '0;
  end
endmodule

// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: bidirectional Johnson / one-hot ring counter with load and wrap pulse
// Define SELF_CORRECT_EN to replace illegal states with the current mode's seed (err pulses).
module ring_johnson_counter
  import ring_ctr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDXW  = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  state_idx,
  output logic             wrap,
  output logic             err
);
`ifdef SELF_CORRECT_EN
  localparam bit CORRECT = 1'b1;
`else
  localparam bit CORRECT = 1'b0;
`endif
  mode_t            mode_r, mode_i;
  logic             legal, wrap_n, err_n, twist;
  logic [WIDTH-1:0] q_n, step;
  assign mode_i = mode_t'(mode);
  assign twist  = (mode_r == MODE_JOHNSON);
  shift_ctr_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec (
    .q    (q),
    .mode (mode_r),
    .legal(legal),
    .idx  (state_idx)
  );
  always_comb begin
    step   = dir ? {q[WIDTH-2:0], q[WIDTH-1] ^ twist} : {q[0] ^ twist, q[WIDTH-1:1]};
    q_n    = q;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (load) q_n = load_val;
    else if (mode_i != mode_r) q_n = WIDTH'(seed_of(mode_i));
    else if (CORRECT && !legal) begin
      q_n   = WIDTH'(seed_of(mode_r));
      err_n = 1'b1;
    end else if (en) begin
      q_n    = step;
      wrap_n = (step == WIDTH'(seed_of(mode_r)));
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q      <= '0;
      mode_r <= MODE_JOHNSON;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      q      <= q_n;
      mode_r <= mode_i;
      wrap   <= wrap_n;
      err    <= err_n;
    end
endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb_ring_johnson_counter: vector table, corner sequences and random model check of ring_johnson_counter
module tb_ring_johnson_counter;
  logic       clk = 1'b0, reset_n = 1'b0, en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0, q;
  logic [2:0] idx;
  logic       wrap, err;
  logic       en8 = 1'b0, dir8 = 1'b0, mode8 = 1'b0, load8 = 1'b0;
  logic [7:0] lv8 = 8'd0, q8;
  logic [3:0] idx8;
  logic       wrap8, err8;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ring_johnson_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .state_idx(idx), .wrap(wrap), .err(err)
  );
  ring_johnson_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .dir(dir8), .mode(mode8), .load(load8),
    .load_val(lv8), .q(q8), .state_idx(idx8), .wrap(wrap8), .err(err8)
  );

  typedef struct {
    logic       en, dir, mode, load;
    logic [3:0] lv, q;
    int         idx;
    logic       wrap;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic e, logic d, logic m, logic l, logic [3:0] lv, logic [3:0] eq,
                             int ei, logic ew);
    vec_t r;
    r.en = e; r.dir = d; r.mode = m; r.load = l; r.lv = lv; r.q = eq; r.idx = ei; r.wrap = ew;
    return r;
  endfunction

  // pattern at position k of a width-w sequence: ring = single one walking down from the top,
  // Johnson = ones filling in from the MSB, then draining out of the MSB
  function automatic logic [31:0] pat(int w, logic m, int k);
    logic [31:0] one;
    one = 32'd1;
    if (m) return one << ((w - k) % w);
    return (k <= w) ? ((one << k) - 32'd1) << (w - k) : (one << (2 * w - k)) - 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] eq, input int ei, input logic ew,
                      input logic ee);
    chk({nm, "_q"}, 32'(q), 32'(eq));
    chk({nm, "_idx"}, 32'(idx), 32'(ei));
    chk({nm, "_wrap"}, 32'(wrap), 32'(ew));
    chk({nm, "_err"}, 32'(err), 32'(ee));
  endtask

  task automatic apply(input logic e, input logic d, input logic m, input logic l,
                       input logic [3:0] lv);
    en = e; dir = d; mode = m; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  int   k, lk, p;
  logic mm, re, rd, rm, rl, ew;

  initial begin
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h8, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'hC, 2, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'hE, 3, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'hF, 4, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h7, 5, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h3, 6, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h1, 7, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h1, 7, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h3, 6, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h7, 5, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'hF, 4, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'hE, 3, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'hC, 2, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h8, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'h0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h8, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'hC, 2, 0));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'hE, 3, 0));
    tbl.push_back(v(1, 0, 1, 0, 4'h0, 4'h1, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 4'h0, 4'h8, 1, 0));
    tbl.push_back(v(1, 0, 1, 0, 4'h0, 4'h4, 2, 0));
    tbl.push_back(v(1, 0, 1, 0, 4'h0, 4'h2, 3, 0));
    tbl.push_back(v(1, 0, 1, 0, 4'h0, 4'h1, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 4'h0, 4'h1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 4'h0, 4'h1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 4'h7, 4'h7, 5, 0));
    tbl.push_back(v(0, 0, 0, 0, 4'h0, 4'h7, 5, 0));
    tbl.push_back(v(1, 0, 0, 1, 4'h7, 4'h7, 5, 0));
    tbl.push_back(v(1, 1, 0, 0, 4'h0, 4'hF, 4, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 4'h1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 4'h2, 3, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 4'h4, 2, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 4'h8, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 4'h1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 4'h0, 0, 0));

    #12;
    chk4("reset", 4'h0, 0, 0, 0);
    chk("reset_q8", 32'(q8), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].load, tbl[i].lv);
      chk4($sformatf("vec%0d", i), tbl[i].q, tbl[i].idx, tbl[i].wrap, 1'b0);
    end

    // asynchronous reset mid-cycle, then hold and first step
    apply(0, 0, 0, 1, 4'h7);
    chk4("pre_rst", 4'h7, 5, 0, 0);
    load = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk4("async_rst", 4'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk4("rst_held", 4'h0, 0, 0, 0);
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 4'h0);
    chk4("hold0", 4'h0, 0, 0, 0);
    apply(0, 0, 0, 0, 4'h0);
    chk4("hold1", 4'h0, 0, 0, 0);
    apply(1, 0, 0, 0, 4'h0);
    chk4("first_step", 4'h8, 1, 0, 0);

    // mode input high across reset release seeds the ring without en
    reset_n = 1'b0;
    en = 1'b0;
    mode = 1'b1;
    #2;
    reset_n = 1'b1;
    apply(0, 0, 1, 0, 4'h0);
    chk4("rst_ring_seed", 4'h1, 0, 0, 0);
    apply(0, 0, 1, 0, 4'h0);
    chk4("rst_ring_hold", 4'h1, 0, 0, 0);

    // illegal Johnson load
    apply(0, 0, 0, 0, 4'h0);
    chk4("to_johnson", 4'h0, 0, 0, 0);
    apply(0, 0, 0, 1, 4'hA);
    chk4("illegal_load", 4'hA, 0, 0, 0);
`ifdef SELF_CORRECT_EN
    apply(1, 0, 0, 0, 4'h0);
    chk4("corrected", 4'h0, 0, 0, 1);
    apply(0, 0, 0, 0, 4'h0);
    chk4("err_once", 4'h0, 0, 0, 0);
`else
    apply(1, 0, 0, 0, 4'h0);
    chk4("illegal_shift", 4'hD, 0, 0, 0);
    apply(0, 0, 0, 0, 4'h0);
    chk4("illegal_hold", 4'hD, 0, 0, 0);
`endif
    apply(0, 0, 0, 1, 4'h0);
    chk4("reload_seed", 4'h0, 0, 0, 0);

    // random traffic against a position-based model
    k = 0;
    mm = 1'b0;
    for (int c = 0; c < 400; c++) begin
      re = ($urandom_range(3) != 0);
      rd = 1'($urandom_range(1));
      rm = ($urandom_range(9) == 0) ? ~mode : mode;
      rl = ($urandom_range(11) == 0);
      lk = int'($urandom_range(7));
      if (rm) lk = lk % 4;
      apply(re, rd, rm, rl, 4'(pat(4, rm, lk)));
      ew = 1'b0;
      if (rl) k = lk;
      else if (rm != mm) k = 0;
      else if (re) begin
        p  = mm ? 4 : 8;
        k  = rd ? (k + p - 1) % p : (k + 1) % p;
        ew = (k == 0);
      end
      mm = rm;
      chk4($sformatf("rand%0d", c), 4'(pat(4, mm, k)), k, ew, 1'b0);
      if ($urandom_range(39) == 0) begin
        reset_n = 1'b0;
        #1;
        chk($sformatf("rand_rst%0d", c), 32'(q), 32'd0);
        reset_n = 1'b1;
        k = 0;
        mm = 1'b0;
      end
    end

    // WIDTH=8 periods
    en = 1'b0;
    load = 1'b0;
    mode8 = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_ring_seed", 32'(q8), 32'd1);
    en8 = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w8_ring_q%0d", s), 32'(q8), pat(8, 1'b1, s % 8));
      chk($sformatf("w8_ring_idx%0d", s), 32'(idx8), 32'(s % 8));
      chk($sformatf("w8_ring_wrap%0d", s), 32'(wrap8), 32'(s == 8));
    end
    en8 = 1'b0;
    mode8 = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_john_seed", 32'(q8), 32'd0);
    en8 = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w8_john_q%0d", s), 32'(q8), pat(8, 1'b0, s % 16));
      chk($sformatf("w8_john_idx%0d", s), 32'(idx8), 32'(s % 16));
      chk($sformatf("w8_john_wrap%0d", s), 32'(wrap8), 32'(s == 16));
    end
    chk("w8_err", 32'(err8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_johnson_counter.md
RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have derived localparam IDXW = $clog2(2*WIDTH), the width of the state index.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
- clk        input   1      rising-edge clock
- reset_n    input   1      asynchronous reset, active-low
- en         input   1      advance one step this cycle
- dir        input   1      0 = forward, 1 = reverse
- mode       input   1      0 = Johnson (twisted ring), 1 = ring (one-hot rotate)
- load       input   1      synchronous load of load_val
- load_val   input   WIDTH  value loaded when load = 1
- q          output  WIDTH  counter state (registered)
- state_idx  output  IDXW   position of q in the current sequence (combinational from q)
- wrap       output  1      one-cycle pulse, sequence returned to seed by a step
- err        output  1      one-cycle pulse, illegal state corrected

Function
REQ-004 Johnson seed SHALL be all-zeros; ring seed SHALL be 0...01.
REQ-005 Johnson forward step SHALL be q <= {~q[0], q[W-1:1]}; reverse step SHALL be q <= {q[W-2:0], ~q[W-1]}.
- WIDTH=4 forward: 0000,1000,1100,1110,1111,0111,0011,0001,0000.
REQ-006 Ring forward step SHALL be q <= {q[0], q[W-1:1]}; reverse step SHALL be q <= {q[W-2:0], q[W-1]}.
REQ-007 Per-edge priority SHALL be: reset > load > mode change > illegal-state correction > en step > hold.
REQ-008 The block SHALL register mode internally; when the mode input differs from the registered mode, the next edge SHALL load the seed of the new mode, regardless of en.
REQ-009 load SHALL write load_val into q unconditionally, with one-cycle latency.
REQ-010 Johnson state_idx SHALL be popcount(q) when q[0]=0, else 2*WIDTH - popcount(q).
REQ-011 Ring state_idx SHALL be (WIDTH - bitpos) mod WIDTH, where bitpos is the index of the set bit.
REQ-012 state_idx SHALL be 0 for illegal states.
REQ-013 A Johnson state SHALL be legal iff popcount(q ^ (q >> 1)) over the WIDTH-1 adjacent pairs is at most 1.
REQ-014 A ring state SHALL be legal iff popcount(q) = 1.
REQ-015 wrap SHALL be registered and SHALL go high in the same cycle q becomes the seed through an en step, in either direction.
REQ-016 wrap SHALL NOT be asserted when the seed arrives via reset, load, mode change or correction.
REQ-017 With en held low, q SHALL hold, and wrap and err SHALL be 0.

Reset
REQ-018 While reset_n = 0, q SHALL be all-zeros, the registered mode SHALL be 0 (Johnson), and wrap and err SHALL be 0.
REQ-019 Reset assertion mid-sequence SHALL take effect immediately, without waiting for clk.
REQ-020 Reset release SHALL be followed by the first step on the first rising edge with en = 1.
REQ-021 If the mode input is 1 at reset release, the first edge SHALL load the ring seed per REQ-008.

Configuration
REQ-022 Macro SELF_CORRECT_EN SHALL control illegal-state correction.
REQ-023 With SELF_CORRECT_EN defined: an illegal q (for example after load) SHALL be replaced by the current mode's seed on the next edge, and err SHALL pulse for that one cycle.
REQ-024 Without SELF_CORRECT_EN: err SHALL be tied 0, and illegal patterns SHALL simply shift or rotate per REQ-005/006.

Structure
REQ-025 Package ring_ctr_pkg SHALL hold: the mode typedef (MODE_JOHNSON=0, MODE_RING=1), the seed function, and the idx-width function.
REQ-026 One combinational sub-module, shift_ctr_decode, SHALL compute legality and state_idx from q and mode.
REQ-027 All state SHALL be held in the top module.

Verification
REQ-028 WIDTH=4, Johnson, dir=0, en=1 for 8 cycles after reset -> q SHALL be 1000,1100,1110,1111,0111,0011,0001,0000; state_idx SHALL be 1..7 then 0; wrap SHALL be high only on the 0000 cycle.
REQ-029 WIDTH=4, Johnson, dir=1 from 0000 -> q SHALL be 0001,0011,0111,1111,1110,1100,1000,0000; state_idx SHALL be 7,6,...,0.
REQ-030 Switch mode to 1 mid-count at q=1110 -> next q SHALL be 0001 with wrap=0; dir=0 then gives 1000,0100,0010,0001 with wrap on 0001.
REQ-031 With SELF_CORRECT_EN, Johnson mode, load 4'b1010 -> q SHALL be 1010 for one cycle, then 0000 with err=1 for one cycle; without the macro, q SHALL be 1101 after the next step.
REQ-032 reset_n low asynchronously at q=0111 -> q SHALL be 0000 before the next clk edge; en held low SHALL hold q and keep wrap=0.
REQ-033 WIDTH=8 ring mode -> the sequence SHALL have period 8; Johnson mode SHALL have period 16, with state_idx 0..15.
